adder_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 32-bit adder datapath in the MIPS processor. Several requesters (PC incrementer, branch-target calculator, address generator) compete for one adder. Each cycle, at most one request is granted, computed, and returned in a registered result tagged with the requester ID. This keeps a single adder instance in the design and gives the pipeline a deterministic, starvation-free access order.

---
 rtl/adder_arbiter.sv | 143 ++++++++++++++
 tb/tb_adder_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_arbiter
// Description : Round-robin arbiter in front of a single shared 32-bit adder.
//               At most one requester is granted per cycle. Its a+b result
//               is registered and tagged with the requester index.
//               Optional macro ADDER_ARB_OVF_EN enables the registered
//               signed-overflow flag. Without it, ovf is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_arbiter #(
    parameter int NREQ = 3,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*32-1:0] a_in,
    input  logic [NREQ*32-1:0] b_in,
    output logic [NREQ-1:0]    gnt,
    output logic               sum_valid,
    output logic [31:0]        sum_out,
    output logic [IDW-1:0]     sum_id,
    output logic               cout,
    output logic               ovf
);

    localparam logic [IDW-1:0] C_LAST_RST = IDW'(NREQ - 1);

    logic [IDW-1:0] last_q, last_d;
    logic           sum_valid_q, sum_valid_d;
    logic [31:0]    sum_out_q, sum_out_d;
    logic [IDW-1:0] sum_id_q, sum_id_d;
    logic           cout_q, cout_d;

    logic [IDW-1:0] w_hi_idx, w_lo_idx, w_sel_idx;
    logic           w_hi_any, w_lo_any;
    logic           w_grant_fire;
    logic [31:0]    w_a_sel, w_b_sel;
    logic [32:0]    w_sum_full;

    // Round-robin search: the lowest requester above the pointer wins.
    // Otherwise the search wraps to the lowest requester overall.
    always_comb begin
        w_hi_idx = '0;
        w_lo_idx = '0;
        w_hi_any = 1'b0;
        w_lo_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_lo_idx = IDW'(i);
                w_lo_any = 1'b1;
                if (IDW'(i) > last_q) begin
                    w_hi_idx = IDW'(i);
                    w_hi_any = 1'b1;
                end
            end
        end
        w_sel_idx    = w_hi_any ? w_hi_idx : w_lo_idx;
        w_grant_fire = w_lo_any && !stall && !reset;
    end

    // One-hot grant, and the operand mux that feeds the single adder.
    always_comb begin
        gnt     = '0;
        w_a_sel = '0;
        w_b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel_idx == IDW'(i)) begin
                gnt[i]  = w_grant_fire;
                w_a_sel = a_in[32*i +: 32];
                w_b_sel = b_in[32*i +: 32];
            end
        end
        w_sum_full = {1'b0, w_a_sel} + {1'b0, w_b_sel};
    end

    // Next-state: capture the result on a grant, otherwise hold it and
    // drop the valid pulse.
    always_comb begin
        last_d      = last_q;
        sum_valid_d = w_grant_fire;
        sum_out_d   = sum_out_q;
        sum_id_d    = sum_id_q;
        cout_d      = cout_q;
        if (w_grant_fire) begin
            last_d    = w_sel_idx;
            sum_out_d = w_sum_full[31:0];
            sum_id_d  = w_sel_idx;
            cout_d    = w_sum_full[32];
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q      <= C_LAST_RST;
            sum_valid_q <= 1'b0;
            sum_out_q   <= '0;
            sum_id_q    <= '0;
            cout_q      <= 1'b0;
        end else begin
            last_q      <= last_d;
            sum_valid_q <= sum_valid_d;
            sum_out_q   <= sum_out_d;
            sum_id_q    <= sum_id_d;
            cout_q      <= cout_d;
        end
    end

    assign sum_valid = sum_valid_q;
    assign sum_out   = sum_out_q;
    assign sum_id    = sum_id_q;
    assign cout      = cout_q;

`ifdef ADDER_ARB_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow: both operands have the same sign, and the sum sign differs.
    always_comb begin
        ovf_d = ovf_q;
        if (w_grant_fire) begin
            ovf_d = (w_a_sel[31] == w_b_sel[31]) && (w_sum_full[31] != w_a_sel[31]);
        end
    end

    // Overflow flag register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_arbiter
// Description : Directed, self-checking bench for adder_arbiter (NREQ=3).
//               Expected results are queued when a grant is predicted, and
//               popped one cycle later when the result appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  req;
    logic [95:0] a_in;
    logic [95:0] b_in;
    logic [2:0]  gnt;
    logic        sum_valid;
    logic [31:0] sum_out;
    logic [1:0]  sum_id;
    logic        cout;
    logic        ovf;

    adder_arbiter #(.NREQ(3), .IDW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .sum_valid (sum_valid),
        .sum_out   (sum_out),
        .sum_id    (sum_id),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic [31:0] s;
        logic [1:0]  id;
        logic        c;
        logic        o;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        held;
    logic [31:0] a_v [3];
    logic [31:0] b_v [3];
    int          m_last;
    int          checks;
    int          errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int model_pick(input logic [2:0] r, input int last);
        int idx;
        for (int k = 1; k <= 3; k++) begin
            idx = (last + k) % 3;
            if (((r >> idx) & 3'b001) != 3'b000) return idx;
        end
        return -1;
    endfunction

    // One clock cycle: drive the inputs, check the combinational grant,
    // then check the registered outputs after the edge.
    task automatic cycle(input logic [2:0] r, input logic st, input logic rs);
        int          pick;
        logic [2:0]  exp_g;
        logic [32:0] s;
        exp_t        e;
        req   = r;
        stall = st;
        reset = rs;
        a_in  = {a_v[2], a_v[1], a_v[0]};
        b_in  = {b_v[2], b_v[1], b_v[0]};
        #3;
        pick  = (st || rs) ? -1 : model_pick(r, m_last);
        exp_g = (pick >= 0) ? (3'b001 << pick) : 3'b000;
        chk("gnt", {29'd0, gnt}, {29'd0, exp_g});
        if (pick >= 0) begin
            s    = {1'b0, a_v[pick]} + {1'b0, b_v[pick]};
            e.s  = s[31:0];
            e.id = 2'(pick);
            e.c  = s[32];
`ifdef ADDER_ARB_OVF_EN
            e.o  = (a_v[pick][31] == b_v[pick][31]) && (s[31] != a_v[pick][31]);
`else
            e.o  = 1'b0;
`endif
            exp_q.push_back(e);
            m_last = pick;
        end
        if (rs) m_last = 2;
        @(posedge clk);
        #1;
        if (rs) begin
            held = '0;
            chk("rst_valid", {31'd0, sum_valid}, 32'd0);
            chk("rst_sum", sum_out, 32'd0);
            chk("rst_id", {30'd0, sum_id}, 32'd0);
            chk("rst_cout", {31'd0, cout}, 32'd0);
            chk("rst_ovf", {31'd0, ovf}, 32'd0);
        end else if (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            held = e;
            chk("valid", {31'd0, sum_valid}, 32'd1);
            chk("sum", sum_out, e.s);
            chk("id", {30'd0, sum_id}, {30'd0, e.id});
            chk("cout", {31'd0, cout}, {31'd0, e.c});
            chk("ovf", {31'd0, ovf}, {31'd0, e.o});
        end else begin
            chk("idle_valid", {31'd0, sum_valid}, 32'd0);
            chk("hold_sum", sum_out, held.s);
            chk("hold_id", {30'd0, sum_id}, {30'd0, held.id});
            chk("hold_cout", {31'd0, cout}, {31'd0, held.c});
            chk("hold_ovf", {31'd0, ovf}, {31'd0, held.o});
        end
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        a_v[i] = a;
        b_v[i] = b;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_last = 2;
        held   = '0;
        req    = '0;
        stall  = 1'b0;
        reset  = 1'b1;
        for (int i = 0; i < 3; i++) set_ops(i, 32'd0, 32'd0);
        a_in   = '0;
        b_in   = '0;
        #1;

        // Reset for two cycles, then a single request 5+7.
        cycle(3'b000, 1'b0, 1'b1);
        cycle(3'b000, 1'b0, 1'b1);
        set_ops(0, 32'd5, 32'd7);
        cycle(3'b001, 1'b0, 1'b0);
        chk("plan_sum12", sum_out, 32'd12);
        cycle(3'b000, 1'b0, 1'b0);

        // Wrap with carry, then signed overflow.
        set_ops(0, 32'hFFFF_FFFF, 32'd1);
        cycle(3'b001, 1'b0, 1'b0);
        chk("plan_wrap_cout", {31'd0, cout}, 32'd1);
        set_ops(0, 32'h7FFF_FFFF, 32'd1);
        cycle(3'b001, 1'b0, 1'b0);
        cycle(3'b000, 1'b0, 1'b0);

        // Round-robin fairness from a fresh pointer.
        cycle(3'b000, 1'b0, 1'b1);
        set_ops(0, 32'd100, 32'd1);
        set_ops(1, 32'd200, 32'd2);
        set_ops(2, 32'h8000_0000, 32'h8000_0000);
        for (int n = 0; n < 6; n++) cycle(3'b111, 1'b0, 1'b0);
        cycle(3'b000, 1'b0, 1'b0);

        // Stall holds the pointer, then requesters 1 and 2 in order.
        cycle(3'b110, 1'b1, 1'b0);
        cycle(3'b110, 1'b1, 1'b0);
        cycle(3'b110, 1'b0, 1'b0);
        cycle(3'b100, 1'b0, 1'b0);
        cycle(3'b000, 1'b0, 1'b0);

        // Reset in the middle of a burst.
        cycle(3'b111, 1'b0, 1'b0);
        cycle(3'b111, 1'b0, 1'b0);
        cycle(3'b111, 1'b0, 1'b1);
        cycle(3'b111, 1'b0, 1'b0);
        cycle(3'b000, 1'b0, 1'b0);

        // Idle hold after a result of 0x10.
        set_ops(2, 32'h0000_0008, 32'h0000_0008);
        cycle(3'b100, 1'b0, 1'b0);
        chk("plan_sum10", sum_out, 32'h10);
        for (int n = 0; n < 3; n++) cycle(3'b000, 1'b0, 1'b0);

        // Short pseudo-random burst.
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 3; i++) set_ops(i, $urandom, $urandom);
            cycle(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 1'b0);
        end
        cycle(3'b000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
